cpuf_core_p: RTL and testbench

//  Parametrised next-generation CPUFresh core.
//  - Merges PC, IR, MAR, A/B registers, ALU, accumulator and sequencer into one block.
//  - Uses a variable-length FSM instead of the fixed 6-stage ring.
//  - Reaches program/data memory through a req/ack port that tolerates wait states.
//  - Adds flags, conditional jumps, store, ACC->A move, an output port and run/pause control.

---
 rtl/cpuf_core_p.sv | 231 +++++++++++++++++++++++
 tb/tb_cpuf_core_p.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpuf_core_p.sv
// -----------------------------------------------------------------------------
// cpuf_core_p -- parametrised CPUFresh core
//
// Single block holding PC, IR, A, B, ACC, flags and a variable-length
// sequencer. Program and data share one memory reached through a req/ack
// port that tolerates any number of wait states.
//
// Parameters
//   DATA_W    data/instruction width (must be >= ADDR_W+4)
//   ADDR_W    address width; PC wraps modulo 2**ADDR_W
//   RESET_PC  PC value after reset
//
// Ports
//   clk, reset    clock (posedge), synchronous active-high reset
//   run           1 = execute, 0 = pause at the next instruction boundary
//   mem_req       memory request (FETCH and MEM states)
//   mem_we        1 = write (STA), 0 = read
//   mem_addr      PC in FETCH, IR operand in MEM, 0 otherwise
//   mem_wdata     always ACC
//   mem_rdata     read data, valid while mem_ack=1
//   mem_ack       transaction completes on an edge with mem_req && mem_ack
//   out_valid     one-cycle pulse after an OUT instruction
//   out_data      ACC captured by the last OUT
//   halted        1 in HALT
//   pc_o, acc_o   architectural PC and ACC
//   flag_z/flag_c zero and carry/borrow flags
// -----------------------------------------------------------------------------
module cpuf_core_p #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] acc_o,
    output logic              flag_z,
    output logic              flag_c
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    localparam logic [3:0] OP_LDA = 4'b1000;
    localparam logic [3:0] OP_LDB = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_JZ  = 4'b1010;
    localparam logic [3:0] OP_JC  = 4'b1011;
    localparam logic [3:0] OP_STA = 4'b0011;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                z_q, z_d;
    logic                c_q, c_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   operand;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   diff;
    logic [ADDR_W-1:0]   pc_next_seq;
    logic                next_run_state;

    assign opcode      = ir_q[DATA_W-1 -: 4];
    assign operand     = ir_q[ADDR_W-1:0];
    assign sum         = {1'b0, a_q} + {1'b0, b_q};
    assign diff        = a_q - b_q;
    assign pc_next_seq = pc_q + ADDR_W'(1);
    assign next_run_state = run;

    // ------------------------------------------------------------------
    // Next-state and datapath updates. Non-memory instructions commit on
    // the EXEC exit edge; loads commit on the MEM ack edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        z_d         = z_q;
        c_d         = c_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end

            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_next_seq;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (opcode)
                    OP_LDA, OP_LDB, OP_STA: state_d = S_MEM;
                    OP_HLT:                 state_d = S_HALT;
                    default: begin
                        state_d = next_run_state ? S_FETCH : S_IDLE;
                        case (opcode)
                            OP_ADD: begin
                                acc_d = sum[DATA_W-1:0];
                                c_d   = sum[DATA_W];
                                z_d   = (sum[DATA_W-1:0] == '0);
                            end
                            OP_SUB: begin
                                acc_d = diff;
                                c_d   = (a_q < b_q);
                                z_d   = (diff == '0);
                            end
                            // PC already points past this instruction, so
                            // a taken jump simply overwrites it.
                            OP_JMP: pc_d = operand;
                            OP_JZ:  if (z_q) pc_d = operand;
                            OP_JC:  if (c_q) pc_d = operand;
                            OP_MOV: a_d = acc_q;
                            OP_OUT: begin
                                out_data_d  = acc_q;
                                out_valid_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                endcase
            end

            S_MEM: begin
                if (mem_ack) begin
                    if (opcode == OP_LDA) a_d = mem_rdata;
                    if (opcode == OP_LDB) b_d = mem_rdata;
                    state_d = next_run_state ? S_FETCH : S_IDLE;
                end
            end

            S_HALT: ;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_RST;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs. The address/we sources are registers that only move
    // on ack, so they hold steady across wait states.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = (opcode == OP_STA);
                mem_addr = operand;
            end
            default: ;
        endcase
    end

    assign mem_wdata = acc_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign halted    = (state_q == S_HALT);
    assign pc_o      = pc_q;
    assign acc_o     = acc_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;

endmodule

// File: tb/tb_cpuf_core_p.sv
// -----------------------------------------------------------------------------
// Testbench for cpuf_core_p: behavioural memory with programmable wait
// states, a transaction scoreboard and an OUT-port scoreboard.
// -----------------------------------------------------------------------------
module tb_cpuf_core_p;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          halted;
    logic [AW-1:0] pc_o;
    logic [DW-1:0] acc_o;
    logic          flag_z;
    logic          flag_c;

    always #5 clk = ~clk;

    cpuf_core_p #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .halted    (halted),
        .pc_o      (pc_o),
        .acc_o     (acc_o),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t          exp_txn[$];
    logic [DW-1:0] exp_out[$];
    logic [DW-1:0] mem[16];

    int errors = 0;
    int checks = 0;

    int            wait_cycles  = 0;
    int            wcnt         = 0;
    bit            spurious_ack = 1'b0;
    int            write_cnt    = 0;
    bit            prev_pend    = 1'b0;
    logic [AW-1:0] p_addr;
    logic          p_we;
    logic [DW-1:0] p_wdata;
    txn_t          mon_e;
    logic [DW-1:0] mon_o;

    // Memory responder + scoreboards, evaluated on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            mem_ack   = 1'b0;
            wcnt      = 0;
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata) begin
                    errors++;
                    $display("FAIL hold: req=%b addr=%h we=%b wdata=%h, required req=1 addr=%h we=%b wdata=%h",
                             mem_req, mem_addr, mem_we, mem_wdata, p_addr, p_we, p_wdata);
                end
            end
            if (mem_req === 1'b1) begin
                if (wcnt >= wait_cycles) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    wcnt      = 0;
                    prev_pend = 1'b0;
                    checks++;
                    if (exp_txn.size() == 0) begin
                        errors++;
                        $display("FAIL txn: got unexpected addr=%h we=%b, required none", mem_addr, mem_we);
                    end else begin
                        mon_e = exp_txn.pop_front();
                        if (mem_addr !== mon_e.addr || mem_we !== mon_e.we ||
                            (mon_e.we && mem_wdata !== mon_e.wdata)) begin
                            errors++;
                            $display("FAIL txn: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                                     mem_addr, mem_we, mem_wdata, mon_e.addr, mon_e.we, mon_e.wdata);
                        end
                    end
                    if (mem_we === 1'b1) begin
                        mem[mem_addr] = mem_wdata;
                        write_cnt++;
                    end
                end else begin
                    mem_ack   = 1'b0;
                    wcnt++;
                    prev_pend = 1'b1;
                    p_addr    = mem_addr;
                    p_we      = mem_we;
                    p_wdata   = mem_wdata;
                end
            end else begin
                mem_ack   = spurious_ack;
                mem_rdata = 8'hA5;
                wcnt      = 0;
                prev_pend = 1'b0;
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_out.size() == 0) begin
                    errors++;
                    $display("FAIL out: got unexpected out_valid data=%h, required none", out_data);
                end else begin
                    mon_o = exp_out.pop_front();
                    if (out_data !== mon_o) begin
                        errors++;
                        $display("FAIL out: got out_data=%h, required %h", out_data, mon_o);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_rd(input int a);
        txn_t t;
        t.addr  = AW'(a);
        t.we    = 1'b0;
        t.wdata = '0;
        exp_txn.push_back(t);
    endtask

    task automatic push_wr(input int a, input logic [DW-1:0] d);
        txn_t t;
        t.addr  = AW'(a);
        t.we    = 1'b1;
        t.wdata = d;
        exp_txn.push_back(t);
    endtask

    task automatic push_seq(input int s[$]);
        foreach (s[i]) push_rd(s[i]);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'hF0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_txn.delete();
        exp_out.delete();
        @(negedge clk);
    endtask

    task automatic run_until_halt(input string name, input int max, output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL %s halt: halted=%b after %0d cycles, required 1", name, halted, cyc);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_txn.size() != 0 || exp_out.size() != 0) begin
            errors++;
            $display("FAIL %s drained: txn left=%0d out left=%0d, required 0 and 0",
                     name, exp_txn.size(), exp_out.size());
        end
    endtask

    task automatic check_arch(input string name, input logic [AW-1:0] pc, input logic [DW-1:0] acc,
                              input logic z, input logic c);
        checks++;
        if (pc_o !== pc || acc_o !== acc || flag_z !== z || flag_c !== c) begin
            errors++;
            $display("FAIL %s arch: pc=%h acc=%h z=%b c=%b, required pc=%h acc=%h z=%b c=%b",
                     name, pc_o, acc_o, flag_z, flag_c, pc, acc, z, c);
        end
    endtask

    task automatic test_reset();
        int busy;
        do_reset();
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset mem: req=%b we=%b addr=%h wdata=%h, required all 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset out: out_valid=%b out_data=%h halted=%b, required 0 00 0",
                     out_valid, out_data, halted);
        end
        check_arch("reset", 4'h0, 8'h00, 1'b0, 1'b0);
        busy = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_req !== 1'b0) busy++;
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL reset idle: mem_req high %0d cycles with run=0, required 0", busy);
        end
    endtask

    task automatic test_program();
        int cyc;
        do_reset();
        clear_mem();
        mem[0] = 8'h86; mem[1] = 8'h47; mem[2] = 8'h20; mem[3] = 8'hE0; mem[4] = 8'hF0;
        mem[6] = 8'h0E; mem[7] = 8'h0C;
        push_seq('{0, 6, 1, 7, 2, 3, 4});
        exp_out.push_back(8'h1A);
        run = 1'b1;
        run_until_halt("program", 200, cyc);
        checks++;
        if (cyc != 13) begin
            errors++;
            $display("FAIL program latency: %0d cycles to HALT, required 13", cyc);
        end
        check_arch("program", 4'h5, 8'h1A, 1'b0, 1'b0);
        checks++;
        if (out_data !== 8'h1A) begin
            errors++;
            $display("FAIL program out_data: got %h, required 1A", out_data);
        end
        check_drained("program");
    endtask

    task automatic test_sub();
        int cyc;
        do_reset();
        clear_mem();
        mem[0] = 8'h88; mem[1] = 8'h49; mem[2] = 8'h10; mem[3] = 8'hE0; mem[4] = 8'hF0;
        mem[8] = 8'h03; mem[9] = 8'h05;
        push_seq('{0, 8, 1, 9, 2, 3, 4});
        exp_out.push_back(8'hFE);
        run = 1'b1;
        run_until_halt("sub_borrow", 200, cyc);
        check_arch("sub_borrow", 4'h5, 8'hFE, 1'b0, 1'b1);
        check_drained("sub_borrow");

        do_reset();
        mem[8] = 8'h05;
        push_seq('{0, 8, 1, 9, 2, 3, 4});
        exp_out.push_back(8'h00);
        run = 1'b1;
        run_until_halt("sub_zero", 200, cyc);
        check_arch("sub_zero", 4'h5, 8'h00, 1'b1, 1'b0);
        check_drained("sub_zero");
    endtask

    task automatic test_jc();
        int cyc;
        do_reset();
        clear_mem();
        mem[0] = 8'h88; mem[1] = 8'h49; mem[2] = 8'h20; mem[3] = 8'hBA; mem[4] = 8'hF0;
        mem[8] = 8'hFF; mem[9] = 8'h01; mem[10] = 8'hF0;
        push_seq('{0, 8, 1, 9, 2, 3, 10});
        run = 1'b1;
        run_until_halt("jc_taken", 200, cyc);
        check_arch("jc_taken", 4'hB, 8'h00, 1'b1, 1'b1);
        check_drained("jc_taken");

        do_reset();
        mem[9] = 8'h00;
        push_seq('{0, 8, 1, 9, 2, 3, 4});
        run = 1'b1;
        run_until_halt("jc_not_taken", 200, cyc);
        check_arch("jc_not_taken", 4'h5, 8'hFF, 1'b0, 1'b0);
        check_drained("jc_not_taken");
    endtask

    task automatic test_wait_states();
        int cyc, sta_cyc, f3_cyc;
        do_reset();
        clear_mem();
        mem[0] = 8'h88; mem[1] = 8'h49; mem[2] = 8'h20; mem[3] = 8'h3C; mem[4] = 8'hF0;
        mem[8] = 8'h11; mem[9] = 8'h22; mem[12] = 8'h00;
        push_seq('{0, 8, 1, 9, 2, 3});
        push_wr(12, 8'h33);
        push_rd(4);
        wait_cycles  = 3;
        spurious_ack = 1'b1;
        write_cnt    = 0;
        cyc = 0; sta_cyc = 0; f3_cyc = 0;
        run = 1'b1;
        while (halted !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (mem_req === 1'b1 && mem_we === 1'b1) sta_cyc++;
            if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 4'h3) f3_cyc++;
        end
        checks++;
        if (cyc != 38) begin
            errors++;
            $display("FAIL wait latency: %0d cycles to HALT, required 38", cyc);
        end
        checks++;
        if (sta_cyc != 4 || f3_cyc != 4) begin
            errors++;
            $display("FAIL wait req_len: sta=%0d fetch=%0d cycles, required 4 and 4", sta_cyc, f3_cyc);
        end
        checks++;
        if (write_cnt != 1 || mem[12] !== 8'h33) begin
            errors++;
            $display("FAIL wait store: writes=%0d mem[C]=%h, required 1 and 33", write_cnt, mem[12]);
        end
        check_arch("wait", 4'h5, 8'h33, 1'b0, 1'b0);
        check_drained("wait");
        wait_cycles  = 0;
        spurious_ack = 1'b0;
    endtask

    task automatic test_wrap_mov();
        int cyc;
        do_reset();
        clear_mem();
        mem[0]  = 8'hA4; mem[1]  = 8'h9E; mem[14] = 8'h10; mem[15] = 8'h00;
        mem[4]  = 8'h8C; mem[5]  = 8'h4D; mem[6]  = 8'h20; mem[7]  = 8'h60;
        mem[8]  = 8'h20; mem[9]  = 8'hE0; mem[10] = 8'hF0;
        mem[12] = 8'h07; mem[13] = 8'h05;
        push_seq('{0, 1, 14, 15, 0, 4, 12, 5, 13, 6, 7, 8, 9, 10});
        exp_out.push_back(8'h11);
        run = 1'b1;
        run_until_halt("wrap_mov", 300, cyc);
        check_arch("wrap_mov", 4'hB, 8'h11, 1'b0, 1'b0);
        check_drained("wrap_mov");
    endtask

    task automatic test_reset_mid_mem();
        int n, busy;
        do_reset();
        clear_mem();
        mem[0] = 8'h88; mem[1] = 8'h49; mem[2] = 8'h20; mem[3] = 8'hE0; mem[4] = 8'h88;
        mem[8] = 8'h07; mem[9] = 8'h05;
        push_seq('{0, 8, 1, 9, 2, 3, 4});
        exp_out.push_back(8'h0C);
        wait_cycles = 2;
        run = 1'b1;
        n = 0;
        while (!(mem_req === 1'b1 && mem_addr === 4'h8 && acc_o !== 8'h00) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL rst_mid timeout: second LDA MEM phase not reached in %0d cycles", n);
        end
        reset = 1'b1;
        run   = 1'b0;
        @(posedge clk);
        #1;
        prev_pend = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL rst_mid mem: req=%b we=%b addr=%h wdata=%h, required all 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (out_data !== '0 || out_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid out: out_data=%h out_valid=%b halted=%b, required 00 0 0",
                     out_data, out_valid, halted);
        end
        check_arch("rst_mid", 4'h0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        busy = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_req !== 1'b0) busy++;
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL rst_mid idle: mem_req high %0d cycles, required 0", busy);
        end
        check_drained("rst_mid");
        wait_cycles = 0;
    endtask

    task automatic test_run_drop();
        int n, cyc, busy;
        do_reset();
        clear_mem();
        mem[0] = 8'h95; mem[5] = 8'hF0;
        push_rd(0);
        wait_cycles = 3;
        run = 1'b1;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        run = 1'b0;
        busy = 0;
        repeat (12) begin
            @(negedge clk);
            busy = (mem_req === 1'b1) ? busy + 1 : busy;
        end
        checks++;
        if (busy != 3) begin
            errors++;
            $display("FAIL run_drop fetch: req high %0d more cycles after run=0, required 3", busy);
        end
        checks++;
        if (mem_req !== 1'b0 || pc_o !== 4'h5 || halted !== 1'b0) begin
            errors++;
            $display("FAIL run_drop idle: req=%b pc=%h halted=%b, required 0 5 0", mem_req, pc_o, halted);
        end
        check_drained("run_drop_pause");
        push_rd(5);
        run = 1'b1;
        run_until_halt("run_drop_resume", 100, cyc);
        check_arch("run_drop_resume", 4'h6, 8'h00, 1'b0, 1'b0);
        check_drained("run_drop_resume");
        wait_cycles = 0;
    endtask

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        clear_mem();
        test_reset();
        test_program();
        test_sub();
        test_jc();
        test_wait_states();
        test_wrap_mov();
        test_reset_mid_mem();
        test_run_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
